// File: rtl/instr_mem_loader.sv
// Instruction-memory image loader: packs a big-endian byte stream into 32-bit words and serves CPU fetches.
// Optional image checksum is enabled with the LOADER_CHECKSUM_EN macro.
module instr_mem_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic [31:0]       addr_i,
    output logic [31:0]       instr_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd2;
`endif
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MEM_WORDS);

    logic [2:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [23:0]       buf_q, buf_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        ck_total;
`endif

    logic [31:0]       mem [MEM_WORDS];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic              accept;
    logic              len_ok;
    logic              unused_addr;

    assign len_ok = (len_i != '0) && (len_i <= MAX_LEN);
    assign accept = byte_valid_i && byte_ready_o;
    assign wr_idx = word_cnt_q[ADDR_W-1:0];

`ifdef LOADER_CHECKSUM_EN
    assign ck_total = sum_q + byte_i;
`endif

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        buf_d      = buf_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_i) begin
                    if (len_ok) begin
                        state_d    = S_LOAD;
                        len_d      = len_i;
                        lane_d     = '0;
                        word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d      = '0;
`endif
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_i;
`endif
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: buf_d[23:16] = byte_i;
                        2'd1: buf_d[15:8]  = byte_i;
                        2'd2: buf_d[7:0]   = byte_i;
                        default: begin
                            // Lane 3 completes the word; it is written straight from byte_i.
                            wr_en      = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                            if (word_cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                                state_d = S_CHECK;
`else
                                state_d = S_DONE;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (ck_total == 8'd0) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            buf_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Array is not reset: an image survives rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= {buf_q, byte_i};
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready_o = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign byte_ready_o = (state_q == S_LOAD);
`endif
    assign busy_o  = byte_ready_o;
    assign start_o = (state_q == S_DONE);
    assign err_o   = (state_q == S_ERROR);
    assign words_o = word_cnt_q;
    assign instr_o = start_o ? mem[addr_i[ADDR_W+1:2]] : '0;

    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected fetch words go to a scoreboard queue as bytes are sent.
module tb_instr_mem_loader;
    localparam int unsigned MW = 256;
    localparam int unsigned AW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          load_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic [7:0]    byte_i = '0;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    logic [31:0]   addr_i = '0;
    logic [31:0]   instr_o;
    logic          start_o;
    logic          busy_o;
    logic          err_o;
    logic [AW:0]   words_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [7:0]  stim[$];
    logic [31:0] exp_mem[MW];
    int          total = 0;
    int          bad = 0;

    instr_mem_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .len_i(len_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .addr_i(addr_i), .instr_o(instr_o), .start_o(start_o), .busy_o(busy_o),
        .err_o(err_o), .words_o(words_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [AW:0] len);
        @(negedge clk_i);
        load_i = 1'b1;
        len_i  = len;
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    // Appends a correct checksum byte when the checksum feature is built in.
    task automatic finish_stim();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = '0;
        foreach (stim[k]) s = s + stim[k];
        stim.push_back(8'(-s));
`endif
    endtask

    task automatic send_stream(input bit throttle, input int unsigned nwords);
        logic [31:0] w;
        int unsigned wi;
        w  = '0;
        wi = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (throttle && i > 0) begin
                byte_valid_i = 1'b0;
                @(negedge clk_i);
            end
            chk("busy_during_load", busy_o, 1);
            chk("start_low_during_load", start_o, 0);
            byte_i       = stim[i];
            byte_valid_i = 1'b1;
            @(negedge clk_i);
            if (i < int'(4 * nwords)) begin
                w = {w[23:0], stim[i]};
                if (i % 4 == 3) begin
                    exp_mem[wi] = w;
                    sb.push_back('{addr: 32'(wi * 4), data: w});
                    sb.push_back('{addr: 32'(wi * 4 + 4 * MW + 3), data: w});
                    wi++;
                end
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            addr_i = e.addr;
            #1;
            chk(tag, instr_o, e.data);
        end
    endtask

    initial begin
        // Reset defaults
        repeat (2) @(negedge clk_i);
        addr_i = 32'h10;
        #1;
        chk("rst_ready", byte_ready_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_words", 32'(words_o), 0);
        chk("rst_instr", instr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Two-word load, no gaps
        start_load(2);
        addr_i = 0;
        chk("load_busy", busy_o, 1);
        chk("load_ready", byte_ready_o, 1);
        chk("load_words0", 32'(words_o), 0);
        chk("load_instr_nop", instr_o, 0);
        stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        finish_stim();
        send_stream(1'b0, 2);
        chk("two_start", start_o, 1);
        chk("two_busy", busy_o, 0);
        chk("two_words", 32'(words_o), 2);
        drain("two_fetch");

        // Asynchronous reset in the middle of a cycle
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_start", start_o, 0);
        chk("arst_words", 32'(words_o), 0);
        chk("arst_instr", instr_o, 0);
        chk("arst_ready", byte_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Throttled stream
        start_load(2);
        stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        finish_stim();
        send_stream(1'b1, 2);
        chk("thr_start", start_o, 1);
        chk("thr_words", 32'(words_o), 2);
        drain("thr_fetch");

        // Invalid lengths
        start_load(0);
        chk("len0_err", err_o, 1);
        chk("len0_ready", byte_ready_o, 0);
        chk("len0_start", start_o, 0);
        addr_i = 0;
        #1;
        chk("len0_instr", instr_o, 0);
        start_load(9'd257);
        chk("len257_err", err_o, 1);
        chk("len257_ready", byte_ready_o, 0);
        chk("len257_busy", busy_o, 0);

        // Valid load clears the error; load_i mid-load is ignored
        start_load(2);
        chk("recover_err", err_o, 0);
        chk("recover_busy", busy_o, 1);
        load_i = 1'b1;
        len_i  = '0;
        @(negedge clk_i);
        load_i = 1'b0;
        chk("ignore_load_busy", busy_o, 1);
        chk("ignore_load_err", err_o, 0);
        stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        finish_stim();
        send_stream(1'b0, 2);
        chk("recover_start", start_o, 1);
        chk("recover_words", 32'(words_o), 2);
        drain("recover_fetch");

        // Reload from DONE: word 0 overwritten, word 1 kept
        start_load(1);
        addr_i = 0;
        #1;
        chk("reload_start_drop", start_o, 0);
        chk("reload_instr_nop", instr_o, 0);
        stim = '{8'h00, 8'h00, 8'h00, 8'h00};
        finish_stim();
        send_stream(1'b0, 1);
        chk("reload_start", start_o, 1);
        chk("reload_words", 32'(words_o), 1);
        sb.push_back('{addr: 32'd4, data: exp_mem[1]});
        drain("reload_fetch");

`ifdef LOADER_CHECKSUM_EN
        // Checksum accept and reject
        start_load(1);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        send_stream(1'b0, 1);
        chk("ck_good_start", start_o, 1);
        chk("ck_good_err", err_o, 0);
        drain("ck_good_fetch");
        start_load(1);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        send_stream(1'b0, 1);
        sb.delete();
        chk("ck_bad_err", err_o, 1);
        chk("ck_bad_start", start_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction-memory image loader and fetch responder for the single-cycle MIPS CPU. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. It writes those words into an internal instruction array and raises `start_o` once the image is complete, which drives the CPU's `start_i`. On the CPU side it answers instruction fetches: a byte address in, an instruction word out, combinationally.

## Interface
- `MEM_WORDS`, 256: instruction array depth in 32-bit words; power of two.
- `ADDR_W`, 8: log2(`MEM_WORDS`); word-index width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `load_i`  in  1  load request; sampled in IDLE, DONE and ERROR; ignored otherwise.
- `len_i`  in  ADDR_W+1  number of words to load; sampled together with `load_i`.
- `byte_i`  in  8  stream data byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `addr_i`  in  32  CPU fetch byte address (PC).
- `instr_o`  out  32  fetched instruction word.
- `start_o`  out  1  image complete; connects to the CPU's `start_i`.
- `busy_o`  out  1  load in progress.
- `err_o`  out  1  load rejected or failed.
- `words_o`  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- **States:** IDLE, LOAD, CHECK (present only with the configuration macro), DONE, ERROR.
- **Reset:** state IDLE; lane counter, word counter and `words_o` are 0; `byte_ready_o`, `start_o`, `busy_o` and `err_o` are 0. The array contents are not reset.
- **Starting a load:** in IDLE, DONE or ERROR, `load_i`=1 with 1 ≤ `len_i` ≤ `MEM_WORDS` moves the block to LOAD. It latches `len_i` and clears the lane counter, the word counter and the running checksum.
- **Rejected load:** `load_i`=1 with `len_i`=0 or `len_i` > `MEM_WORDS` moves the block to ERROR.
- **Byte transfer:** a byte transfers on any edge where `byte_valid_i` && `byte_ready_o`. `byte_ready_o` = 1 exactly in LOAD and CHECK.
- **Word packing:** lane 0 loads bits [31:24], lane 1 bits [23:16], lane 2 bits [15:8], lane 3 bits [7:0]. The lane counter wraps 3→0.
- **Word write:** on the edge that accepts the lane-3 byte, the assembled word is written to `mem[word_cnt]` and `word_cnt` increments.
- **End of image:** when the incremented count equals the latched length, the next state is DONE (without the macro) or CHECK (with it).
- **`load_i` during LOAD or CHECK** is ignored. The load cannot be aborted except by `rst_i`.
- **Fetch path:**
  - `instr_o` = `mem[addr_i[ADDR_W+1:2]]` when the state is DONE.
  - In every other state `instr_o` = 0 (MIPS nop).
  - `addr_i[1:0]` and the upper address bits are ignored, so addresses wrap modulo 4·`MEM_WORDS`.
- **Status outputs:**
  - `start_o` = 1 iff DONE.
  - `busy_o` = 1 iff LOAD or CHECK.
  - `err_o` = 1 iff ERROR.
  - `words_o` = current word count.
- **Leaving ERROR:** ERROR is left only by a valid `load_i` or by `rst_i`.

## Timing
- **Write-to-read latency:** a word written on edge N is visible on `instr_o` from cycle N+1, provided the state is DONE.
- **`start_o` rise:** `start_o` rises on the edge accepting the final image byte (the lane-3 byte of the last word, or the checksum byte). It is high during the following cycle.
- **Reload from DONE:** `load_i` in DONE drops `start_o` and forces `instr_o` to 0 on the next edge. The CPU is therefore held off during the reload.
- **Throughput:** one byte per cycle when `byte_valid_i` is held high. A gap in `byte_valid_i` stalls without any state loss.
- **Asynchronous reset:** `rst_i` forces all outputs to their reset values immediately, independent of `clk_i`. Partially assembled words are discarded. Array words already written remain.

## Configuration
- **Macro:** `LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit running sum, modulo 256, accumulates every data byte.
  - After the last word the state is CHECK, which accepts exactly one checksum byte.
  - If (sum + checksum byte) mod 256 = 0, the next state is DONE; otherwise it is ERROR.
- **Undefined:** there is no CHECK state and no checksum byte. The last data byte leads directly to DONE.

## Test plan
- **Reset defaults:** assert `rst_i` mid-cycle → all outputs 0 asynchronously; `instr_o`=0 for any `addr_i`.
- **Two-word load:** `len_i`=2, then bytes 20 08 00 05 8C 09 00 04 with no gaps → `start_o`=1 in the cycle after byte 8. With `addr_i`=0, `instr_o`=0x20080005; with `addr_i`=4, `instr_o`=0x8C090004; `words_o`=2.
- **Throttled stream:** the same load with `byte_valid_i` low every other cycle → identical memory and `words_o`, and `start_o` rises 1 cycle after the last accepted byte.
- **Invalid length:**
  - `len_i`=0 → `err_o`=1 next cycle and `byte_ready_o`=0.
  - `len_i`=257 with `MEM_WORDS`=256 → same response.
  - A valid load afterwards clears `err_o`.
- **Reload from DONE:** `load_i` in DONE with `len_i`=1 and bytes 00 00 00 00 → `start_o` low for 4 byte cycles; word 0 becomes 0 while word 1 is unchanged.
- **Checksum (`LOADER_CHECKSUM_EN`):** `len_i`=1, bytes 01 02 03 04, then checksum F6 → DONE. Checksum F5 instead → `err_o`=1 and `start_o`=0.
